// File: rtl/core_ifu_fetch_ctrl.sv
// core_ifu_fetch_ctrl: sequential fetch PC issue to the LSU, PC tagging of returned instructions, redirect squash and a decode output register
`timescale 1ns/1ps
module core_ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] ADDR_STEP = 32'd1,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1,
  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          lsu_rx_valid,
  input  logic          lsu_rx_ready,
  output logic [31:0]   lsu_rx_addr,
  input  logic          lsu_tx_valid,
  output logic          lsu_tx_ready,
  input  logic [31:0]   lsu_tx_inst,
  output logic          ifu_tx_valid,
  input  logic          ifu_tx_ready,
  output logic [31:0]   ifu_tx_pc,
  output logic [31:0]   ifu_tx_inst,
  output logic [CW-1:0] outstanding_cnt
);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);
  logic [31:0] pc_q, pc_d, ifu_pc_q, ifu_pc_d, ifu_inst_q, ifu_inst_d, tag;
  logic [CW-1:0] cnt_q, cnt_d, disc_q, disc_d;
  logic [AW-1:0] wp_q, rp_q;
  logic [31:0] tag_q [MAX_OUTSTANDING];
  logic ifu_valid_q, ifu_valid_d, issue, rsp_fire, drop, deliver, hold;
  always_comb begin
    lsu_rx_valid = rstn && !redirect_valid && cnt_q < MAX_C;
    lsu_rx_addr = pc_q;
    issue = lsu_rx_valid && lsu_rx_ready;
    drop = disc_q != '0 || redirect_valid;
    lsu_tx_ready = cnt_q != '0 && (drop || !ifu_valid_q || ifu_tx_ready);
    rsp_fire = lsu_tx_valid && lsu_tx_ready;
    deliver = rsp_fire && !drop;
    hold = ifu_valid_q && !ifu_tx_ready && !redirect_valid;
    tag = tag_q[rp_q];
    pc_d = redirect_valid ? redirect_pc : issue ? pc_q + ADDR_STEP : pc_q;
    cnt_d = cnt_q + CW'(issue) - CW'(rsp_fire);
    disc_d = redirect_valid ? cnt_q - CW'(rsp_fire) : disc_q - CW'(rsp_fire && disc_q != '0);
    ifu_valid_d = deliver || hold;
    ifu_pc_d = deliver ? tag : hold ? ifu_pc_q : '0;
    ifu_inst_d = deliver ? lsu_tx_inst : hold ? ifu_inst_q : '0;
  end
  assign ifu_tx_valid = ifu_valid_q;
  assign ifu_tx_pc = ifu_pc_q;
  assign ifu_tx_inst = ifu_inst_q;
  assign outstanding_cnt = cnt_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= RESET_PC;
      cnt_q <= '0;
      disc_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      ifu_valid_q <= 1'b0;
      ifu_pc_q <= '0;
      ifu_inst_q <= '0;
    end else begin
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      disc_q <= disc_d;
      wp_q <= wp_q + AW'(issue);
      rp_q <= rp_q + AW'(rsp_fire);
      ifu_valid_q <= ifu_valid_d;
      ifu_pc_q <= ifu_pc_d;
      ifu_inst_q <= ifu_inst_d;
    end
  end
  // tag storage needs no reset: occupancy is tracked by the pointers and cnt_q
  always_ff @(posedge clk) begin
    if (issue) tag_q[wp_q] <= pc_q;
  end
endmodule

// File: tb/tb_core_ifu_fetch_ctrl.sv
// tb_core_ifu_fetch_ctrl: random/directed stimulus with a 3-cycle LSU model and a queue-based reference of the fetch stream
`timescale 1ns/1ps
module tb_core_ifu_fetch_ctrl;
  localparam int MAXO = 8;
  localparam logic [31:0] RPC = 32'h0;
  logic clk = 0, rstn, redirect_valid = 0, lsu_rx_ready = 0, lsu_tx_valid = 0, ifu_tx_ready = 0;
  logic [31:0] redirect_pc = 0, lsu_tx_inst = 0;
  logic lsu_rx_valid, lsu_tx_ready, ifu_tx_valid;
  logic [31:0] lsu_rx_addr, ifu_tx_pc, ifu_tx_inst;
  logic [3:0] outstanding_cnt;
  core_ifu_fetch_ctrl #(.RESET_PC(RPC), .ADDR_STEP(32'd1), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rstn(rstn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .lsu_rx_valid(lsu_rx_valid), .lsu_rx_ready(lsu_rx_ready), .lsu_rx_addr(lsu_rx_addr),
    .lsu_tx_valid(lsu_tx_valid), .lsu_tx_ready(lsu_tx_ready), .lsu_tx_inst(lsu_tx_inst),
    .ifu_tx_valid(ifu_tx_valid), .ifu_tx_ready(ifu_tx_ready), .ifu_tx_pc(ifu_tx_pc),
    .ifu_tx_inst(ifu_tx_inst), .outstanding_cnt(outstanding_cnt));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; logic stale;} fl_t;
  typedef struct {logic [31:0] addr; int due;} lp_t;
  fl_t infl[$];
  logic [31:0] expq[$];
  lp_t pipe[$];
  logic [31:0] rspq[$];
  logic [31:0] mpc = RPC;
  int cyc = 0, acc_cnt = 0, checks = 0, failures = 0;
  logic tmo = 0, tmo_logged = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", n, act, req, cyc);
    end
  endtask
  // monitor: compares DUT outputs against the reference state before it advances
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_ifu_valid", {31'b0, ifu_tx_valid}, 32'd0);
      chk("rst_cnt", {28'b0, outstanding_cnt}, 32'd0);
      chk("rst_rx_valid", {31'b0, lsu_rx_valid}, 32'd0);
    end else begin
      chk("rx_valid", {31'b0, lsu_rx_valid}, {31'b0, !redirect_valid && infl.size() < MAXO});
      if (lsu_rx_valid) chk("rx_addr", lsu_rx_addr, mpc);
      chk("outstanding", {28'b0, outstanding_cnt}, infl.size());
      chk("tx_ready", {31'b0, lsu_tx_ready}, {31'b0, infl.size() != 0 &&
          (infl[0].stale || redirect_valid || expq.size() == 0 || ifu_tx_ready)});
      chk("pair_valid", {31'b0, ifu_tx_valid}, {31'b0, expq.size() != 0});
      if (ifu_tx_valid && expq.size() != 0) begin
        chk("pair_pc", ifu_tx_pc, expq[0]);
        chk("pair_inst", ifu_tx_inst, expq[0]);
      end
    end
    if (tmo && !tmo_logged) begin
      chk("progress_timeout", {31'b0, tmo}, 32'd0);
      tmo_logged = 1;
    end
  end
  // reference model and LSU model (mem[a] = a, 3-cycle latency)
  always begin
    fl_t f;
    lp_t p;
    logic rxf, txf, acc;
    @(negedge clk);
    #1;
    if (!rstn) begin
      infl.delete(); expq.delete(); pipe.delete(); rspq.delete();
      mpc = RPC;
    end else begin
      rxf = lsu_rx_valid && lsu_rx_ready;
      txf = lsu_tx_valid && lsu_tx_ready;
      acc = ifu_tx_valid && ifu_tx_ready;
      if (acc && expq.size() != 0) begin
        void'(expq.pop_front());
        acc_cnt++;
      end
      if (redirect_valid) expq.delete();
      if (txf && infl.size() != 0) begin
        f = infl.pop_front();
        if (rspq.size() != 0) void'(rspq.pop_front());
        if (!f.stale && !redirect_valid) expq.push_back(f.addr);
      end
      if (redirect_valid) begin
        foreach (infl[i]) infl[i].stale = 1'b1;
        mpc = redirect_pc;
      end
      if (rxf) begin
        infl.push_back('{mpc, 1'b0});
        pipe.push_back('{lsu_rx_addr, cyc + 3});
        mpc = mpc + 32'd1;
      end
      while (pipe.size() != 0 && pipe[0].due <= cyc + 1) begin
        p = pipe.pop_front();
        rspq.push_back(p.addr);
      end
    end
  end
  task automatic step(input logic ir, input logic rr, input logic rv, input logic [31:0] rp);
    @(posedge clk);
    #1;
    cyc++;
    ifu_tx_ready = ir;
    lsu_rx_ready = rr;
    redirect_valid = rv;
    redirect_pc = rp;
    lsu_tx_valid = rspq.size() != 0;
    lsu_tx_inst = rspq.size() != 0 ? rspq[0] : 32'd0;
  endtask
  task automatic stream(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
  endtask
  initial begin
    int target, n;
    rstn = 1;
    #2 rstn = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
    rstn = 1;
    stream(30);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
    stream(30);
    for (int i = 0; i < 50 && outstanding_cnt < 5; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h10);
    stream(25);
    for (int i = 0; i < 60; i++) begin
      step(1'b1, outstanding_cnt < 4, 1'b0, 32'd0);
      if (outstanding_cnt == 4 && lsu_tx_valid) begin
        redirect_pc = 32'hFFFF_FFFE;
        redirect_valid = 1'b1;
        break;
      end
    end
    stream(25);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    stream(25);
    target = acc_cnt + 200;
    n = 0;
    while (acc_cnt < target && n < 4000) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, $urandom);
      n++;
    end
    if (acc_cnt < target) tmo = 1;
    stream(12);
    @(posedge clk);
    #1 rstn = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
    rstn = 1;
    stream(30);
    n = 0;
    while ((infl.size() != 0 || expq.size() != 0) && n < 300) begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      n++;
    end
    if (n >= 300) tmo = 1;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
